// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard, forwarding and stall unit for the 5-stage RV32 pipeline.
//   Each architectural register r != 0 has a scoreboard entry that holds
//   valid, producer class and pipeline age. The age is 1 in EX, 2 in MEM
//   and 3 in WB. Load-use stalls, multi-cycle EX holds and the forwarding
//   selects are all derived from these entries.
//
//   Optional build macro: HAZARD_PERF_EN adds three 32-bit event counters.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   id_valid/rs1/rs2/rs*_used    ID-stage instruction and its sources
//   id_rd/id_regwrite/id_class   ID-stage destination and producer class
//                                (00 ALU, 01 load, 10 multi-cycle, 11 other)
//   branch_taken                 taken branch resolved in EX
//   iready_n, dready_n, dbusy    cache handshakes
//   mem_rw_mem                   MEM access type: [1] read, [0] write
//   stall_*                      hold the stage register
//   nop_*                        load a bubble into the stage register
//   fwd_sel_rs1/rs2              EX operand source (registered):
//                                00 regfile, 01 EX/MEM, 10 MEM/WB
//   perf_*_cnt                   event counters (HAZARD_PERF_EN only)

// One scoreboard entry. Its age advances EX -> MEM -> WB and the entry
// then retires. An age-1 producer stays in EX while a multi-cycle op holds EX.
module hazard_sb_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       wr,
    input  logic [1:0] wr_cls,
    input  logic       adv1,
    output logic       valid,
    output logic [1:0] cls,
    output logic [1:0] age
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            cls   <= 2'b00;
            age   <= 2'd0;
        end else if (!hold) begin
            if (wr) begin
                // The youngest producer overwrites. A fresh write does not age on this edge.
                valid <= 1'b1;
                cls   <= wr_cls;
                age   <= 2'd1;
            end else if (valid) begin
                case (age)
                    2'd1:    if (adv1) age <= 2'd2;
                    2'd2:    age <= 2'd3;
                    2'd3: begin
                        // The WB write lands on this edge, and the regfile is write-first.
                        valid <= 1'b0;
                        age   <= 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int MDIV_LAT = 4,
    parameter int CNT_W    = 3,
    localparam int IDX_W   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [IDX_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic [1:0]       id_class,
    input  logic             branch_taken,
    input  logic             iready_n,
    input  logic             dready_n,
    input  logic             dbusy,
    input  logic [1:0]       mem_rw_mem,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             nop_if,
    output logic             nop_id,
    output logic             nop_ex,
    output logic             nop_mem,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_loaduse_cnt,
    output logic [31:0]      perf_mdiv_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);
    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_MDIV = 2'b10;

    logic [NREG-1:0]       ent_valid;
    logic [NREG-1:0][1:0]  ent_cls;
    logic [NREG-1:0][1:0]  ent_age;
    logic [CNT_W-1:0]      mdiv_cnt;

    logic mem_stall, mdiv_busy, accept, load_use;
    logic hz1, hz2, lu1, lu2;

    assign mem_stall = iready_n | (dready_n & mem_rw_mem[1]) | (dbusy & mem_rw_mem[0]);
    assign mdiv_busy = (mdiv_cnt != '0);

    // x0 is never tracked, so its entry is tied off.
    assign ent_valid[0] = 1'b0;
    assign ent_cls[0]   = 2'b00;
    assign ent_age[0]   = 2'd0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        hazard_sb_entry u_ent (
            .clk    (clk),
            .rst    (rst),
            .hold   (mem_stall),
            .wr     (accept & id_regwrite & (id_rd == IDX_W'(r))),
            .wr_cls (id_class),
            .adv1   (~mdiv_busy),
            .valid  (ent_valid[r]),
            .cls    (ent_cls[r]),
            .age    (ent_age[r])
        );
    end

    assign hz1 = id_rs1_used & (id_rs1 != '0) & ent_valid[id_rs1];
    assign hz2 = id_rs2_used & (id_rs2 != '0) & ent_valid[id_rs2];
    assign lu1 = hz1 & (ent_cls[id_rs1] == CLS_LOAD) & (ent_age[id_rs1] == 2'd1);
    assign lu2 = hz2 & (ent_cls[id_rs2] == CLS_LOAD) & (ent_age[id_rs2] == 2'd1);
    assign load_use = lu1 | lu2;

    // Priority: reset, then memory stall, then branch flush, then multi-cycle hold, then load-use.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        nop_if    = 1'b0;
        nop_id    = 1'b0;
        nop_ex    = 1'b0;
        nop_mem   = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                stall_wb  = 1'b1;
            end else if (branch_taken) begin
                nop_if = 1'b1;
                nop_id = 1'b1;
                nop_ex = 1'b1;
            end else if (mdiv_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                nop_mem  = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                nop_ex   = 1'b1;
            end
        end
    end

    assign accept = id_valid & ~mem_stall & ~branch_taken & ~stall_id;

    // The forward source depends on the producer's age when the consumer leaves ID.
    function automatic logic [1:0] fwd_code(input logic hz, input logic [1:0] age);
        if (!hz)              return 2'b00;
        else if (age == 2'd1) return 2'b01;
        else if (age == 2'd2) return 2'b10;
        else                  return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel_rs1 <= 2'b00;
            fwd_sel_rs2 <= 2'b00;
            mdiv_cnt    <= '0;
        end else if (!mem_stall) begin
            if (accept) begin
                fwd_sel_rs1 <= fwd_code(hz1, ent_age[id_rs1]);
                fwd_sel_rs2 <= fwd_code(hz2, ent_age[id_rs2]);
                if (id_class == CLS_MDIV)
                    mdiv_cnt <= CNT_W'(MDIV_LAT - 1);
            end else if (mdiv_busy) begin
                mdiv_cnt <= mdiv_cnt - 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loaduse_cnt <= '0;
            perf_mdiv_cnt    <= '0;
            perf_flush_cnt   <= '0;
        end else if (!mem_stall) begin
            if (load_use & ~branch_taken & ~mdiv_busy)
                perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
            if (mdiv_busy)
                perf_mdiv_cnt <= perf_mdiv_cnt + 32'd1;
            if (branch_taken)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
